// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand stage: opcodes, ALU signal codes
// and the two-entry buffer state type.
package alu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;

   localparam logic [5:0] SIG_NONE = 6'd0;
   localparam logic [5:0] SIG_ADD  = 6'd32;
   localparam logic [5:0] SIG_SUB  = 6'd34;
   localparam logic [5:0] SIG_AND  = 6'd36;
   localparam logic [5:0] SIG_OR   = 6'd37;
   localparam logic [5:0] SIG_SLT  = 6'd42;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_TWO
   } buf_state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode/extend of one instruction into ALU operands.
// Ports: opcode/funct/rs/rt/rd/rs_data/rt_data/imm in, fwd_* bypass in,
// signal/a/b/dest/illegal out. Bypass is active only with ALU_FORWARD_EN.
module alu_decode
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [5:0]        opcode_i,
   input  logic [5:0]        funct_i,
   input  logic [4:0]        rs_i,
   input  logic [4:0]        rt_i,
   input  logic [4:0]        rd_i,
   input  logic [DATA_W-1:0] rs_data_i,
   input  logic [DATA_W-1:0] rt_data_i,
   input  logic [15:0]       imm_i,
   input  logic              fwd_valid_i,
   input  logic [4:0]        fwd_dest_i,
   input  logic [DATA_W-1:0] fwd_data_i,
   output logic [5:0]        signal_o,
   output logic [DATA_W-1:0] a_o,
   output logic [DATA_W-1:0] b_o,
   output logic [4:0]        dest_o,
   output logic              illegal_o
);

   logic              legal;
   logic              rtype;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] a_src;
   logic [DATA_W-1:0] b_src;

   always_comb begin
      legal    = 1'b0;
      rtype    = 1'b0;
      signal_o = SIG_NONE;
      dest_o   = 5'd0;
      imm_ext  = '0;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               SIG_ADD, SIG_SUB, SIG_AND, SIG_OR, SIG_SLT: begin
                  legal    = 1'b1;
                  rtype    = 1'b1;
                  signal_o = funct_i;
                  dest_o   = rd_i;
               end
               default: ;
            endcase
         end
         OP_ADDI, OP_SLTI: begin
            legal    = 1'b1;
            signal_o = (opcode_i == OP_ADDI) ? SIG_ADD : SIG_SLT;
            dest_o   = rt_i;
            imm_ext  = {{(DATA_W-16){imm_i[15]}}, imm_i};
         end
         OP_ANDI, OP_ORI: begin
            legal    = 1'b1;
            signal_o = (opcode_i == OP_ANDI) ? SIG_AND : SIG_OR;
            dest_o   = rt_i;
            imm_ext  = {{(DATA_W-16){1'b0}}, imm_i};
         end
         default: ;
      endcase
   end

`ifdef ALU_FORWARD_EN
   logic fwd_hit_rs;
   logic fwd_hit_rt;
   assign fwd_hit_rs = fwd_valid_i && (fwd_dest_i != 5'd0)
                       && (fwd_dest_i == rs_i);
   assign fwd_hit_rt = fwd_valid_i && (fwd_dest_i != 5'd0)
                       && (fwd_dest_i == rt_i);
   assign a_src = fwd_hit_rs ? fwd_data_i : rs_data_i;
   // rt is a destination for I-type, so only R-type B is bypassed
   assign b_src = rtype ? (fwd_hit_rt ? fwd_data_i : rt_data_i)
                        : imm_ext;
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_valid_i, fwd_dest_i, fwd_data_i, rs_i};
   assign a_src = rs_data_i;
   assign b_src = rtype ? rt_data_i : imm_ext;
`endif

   assign a_o       = legal ? a_src : '0;
   assign b_o       = legal ? b_src : '0;
   assign illegal_o = ~legal;

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: decodes an instruction and holds it in a two-entry
// (main + skid) buffer. Ports: clk/reset, in_* valid/ready upstream with
// instruction fields, fwd_* bypass, out_* valid/ready to EX. The bypass
// is enabled by defining ALU_FORWARD_EN.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [5:0]        in_funct,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [DATA_W-1:0] in_rs_data,
   input  logic [DATA_W-1:0] in_rt_data,
   input  logic [15:0]       in_imm,
   input  logic              fwd_valid,
   input  logic [4:0]        fwd_dest,
   input  logic [DATA_W-1:0] fwd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [5:0]        out_signal,
   output logic [DATA_W-1:0] out_data_a,
   output logic [DATA_W-1:0] out_data_b,
   output logic [4:0]        out_dest,
   output logic              out_illegal
);

   localparam int EW = 6 + 2 * DATA_W + 5 + 1;

   logic [5:0]        dec_signal;
   logic [DATA_W-1:0] dec_a;
   logic [DATA_W-1:0] dec_b;
   logic [4:0]        dec_dest;
   logic              dec_illegal;
   logic [EW-1:0]     dec_e;

   buf_state_e    state_q;
   logic [EW-1:0] main_q;
   logic [EW-1:0] skid_q;
   logic          accept;
   logic          pop;

   alu_decode #(.DATA_W(DATA_W)) u_decode (
      .opcode_i   (in_opcode),
      .funct_i    (in_funct),
      .rs_i       (in_rs),
      .rt_i       (in_rt),
      .rd_i       (in_rd),
      .rs_data_i  (in_rs_data),
      .rt_data_i  (in_rt_data),
      .imm_i      (in_imm),
      .fwd_valid_i(fwd_valid),
      .fwd_dest_i (fwd_dest),
      .fwd_data_i (fwd_data),
      .signal_o   (dec_signal),
      .a_o        (dec_a),
      .b_o        (dec_b),
      .dest_o     (dec_dest),
      .illegal_o  (dec_illegal)
   );

   assign dec_e = {dec_signal, dec_a, dec_b, dec_dest, dec_illegal};

   assign in_ready  = (state_q != BUF_TWO);
   assign out_valid = (state_q != BUF_EMPTY);
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign {out_signal, out_data_a, out_data_b, out_dest, out_illegal} = main_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BUF_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         unique case (state_q)
            BUF_EMPTY: begin
               if (accept) begin
                  state_q <= BUF_ONE;
                  main_q  <= dec_e;
               end
            end
            BUF_ONE: begin
               if (accept && pop) begin
                  main_q <= dec_e;
               end else if (accept) begin
                  state_q <= BUF_TWO;
                  skid_q  <= dec_e;
               end else if (pop) begin
                  state_q <= BUF_EMPTY;
               end
            end
            BUF_TWO: begin
               if (pop) begin
                  state_q <= BUF_ONE;
                  main_q  <= skid_q;
               end
            end
            default: state_q <= BUF_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table,
// hand sequences for buffering/reset, and random traffic vs a queue model.
module tb_alu_operand_stage;

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [15:0] imm;
      logic        fv;
      logic [4:0]  fd;
      logic [31:0] fdata;
   } in_t;

   typedef struct packed {
      logic [5:0]  sig;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dest;
      logic        ill;
   } exp_t;

   typedef struct packed {
      in_t  i;
      exp_t e;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_signal;
   logic [31:0] out_data_a;
   logic [31:0] out_data_b;
   logic [4:0]  out_dest;
   logic        out_illegal;
   in_t         cur;

   int checks   = 0;
   int failures = 0;

   alu_operand_stage #(.DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (cur.op),
      .in_funct   (cur.fn),
      .in_rs      (cur.rs),
      .in_rt      (cur.rt),
      .in_rd      (cur.rd),
      .in_rs_data (cur.rsd),
      .in_rt_data (cur.rtd),
      .in_imm     (cur.imm),
      .fwd_valid  (cur.fv),
      .fwd_dest   (cur.fd),
      .fwd_data   (cur.fdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_signal (out_signal),
      .out_data_a (out_data_a),
      .out_data_b (out_data_b),
      .out_dest   (out_dest),
      .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input exp_t e);
      chk({name, ".signal"}, 64'(out_signal), 64'(e.sig));
      chk({name, ".a"}, 64'(out_data_a), 64'(e.a));
      chk({name, ".b"}, 64'(out_data_b), 64'(e.b));
      chk({name, ".dest"}, 64'(out_dest), 64'(e.dest));
      chk({name, ".illegal"}, 64'(out_illegal), 64'(e.ill));
   endtask

   // Reference: instruction semantics stated directly, no buffer detail
   function automatic exp_t model(input in_t i);
      exp_t e;
      bit   rtype;
      bit   legal;
      bit   fwd_ok;
      e      = '0;
      rtype  = (i.op == 0) && (i.fn inside {32, 34, 36, 37, 42});
      legal  = 1'b1;
      fwd_ok = i.fv && (i.fd != 0);
      if (rtype) begin
         e.sig = i.fn; e.b = i.rtd; e.dest = i.rd;
      end else if (i.op == 8 || i.op == 10) begin
         e.sig  = (i.op == 8) ? 6'd32 : 6'd42;
         e.b    = 32'(int'($signed(i.imm)));
         e.dest = i.rt;
      end else if (i.op == 12 || i.op == 13) begin
         e.sig  = (i.op == 12) ? 6'd36 : 6'd37;
         e.b    = 32'(i.imm);
         e.dest = i.rt;
      end else begin
         legal = 1'b0;
      end
      if (legal) begin
         e.a = i.rsd;
`ifdef ALU_FORWARD_EN
         if (fwd_ok && i.fd == i.rs) e.a = i.fdata;
         if (rtype && fwd_ok && i.fd == i.rt) e.b = i.fdata;
`else
         if (fwd_ok) e.a = i.rsd;
`endif
      end
      e.ill = !legal;
      return e;
   endfunction

   function automatic in_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [15:0] imm);
      in_t i;
      i = '0;
      i.op = op; i.fn = fn; i.rs = 5'd5; i.rt = 5'd6; i.rd = 5'd7;
      i.rsd = rsd; i.rtd = rtd; i.imm = imm;
      return i;
   endfunction

   function automatic exp_t ex(input logic [5:0] sig, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] dest,
                               input logic ill);
      exp_t e;
      e.sig = sig; e.a = a; e.b = b; e.dest = dest; e.ill = ill;
      return e;
   endfunction

   vec_t vt[$];
   exp_t q[$];

   initial begin
      in_t   t;
      in_t   sa;
      in_t   sb;
      exp_t  e0;
      exp_t  zero_e;
      bit    acc;
      bit    pp;
      zero_e = '0;

      vt.push_back('{mk(0, 34, 10, 3, 0), ex(34, 10, 3, 7, 0)});
      vt.push_back('{mk(0, 32, 32'h100, 32'h23, 16'h55), ex(32, 32'h100, 32'h23, 7, 0)});
      vt.push_back('{mk(0, 36, 32'hF0F0, 32'hFF00, 0), ex(36, 32'hF0F0, 32'hFF00, 7, 0)});
      vt.push_back('{mk(0, 37, 1, 2, 0), ex(37, 1, 2, 7, 0)});
      vt.push_back('{mk(0, 42, 32'hFFFF_FFFF, 4, 0), ex(42, 32'hFFFF_FFFF, 4, 7, 0)});
      vt.push_back('{mk(12, 0, 9, 8, 16'hFFFF), ex(36, 9, 32'h0000_FFFF, 6, 0)});
      vt.push_back('{mk(10, 0, 9, 8, 16'hFFFF), ex(42, 9, 32'hFFFF_FFFF, 6, 0)});
      vt.push_back('{mk(8, 0, 2, 8, 16'h8000), ex(32, 2, 32'hFFFF_8000, 6, 0)});
      vt.push_back('{mk(13, 0, 2, 8, 16'h8001), ex(37, 2, 32'h0000_8001, 6, 0)});
      vt.push_back('{mk(6'h3F, 0, 2, 8, 16'h1234), ex(0, 0, 0, 0, 1)});
      vt.push_back('{mk(0, 1, 2, 8, 0), ex(0, 0, 0, 0, 1)});
      t = mk(0, 32, 32'h11, 32'h22, 0);
      t.fv = 1; t.fd = 5; t.fdata = 32'hDEAD;
`ifdef ALU_FORWARD_EN
      vt.push_back('{t, ex(32, 32'hDEAD, 32'h22, 7, 0)});
`else
      vt.push_back('{t, ex(32, 32'h11, 32'h22, 7, 0)});
`endif
      t.fd = 0;
      vt.push_back('{t, ex(32, 32'h11, 32'h22, 7, 0)});

      cur = '0; in_valid = 0; out_ready = 0; reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst.out_valid", 64'(out_valid), 0);
      chk("rst.in_ready", 64'(in_ready), 1);
      chk_out("rst", zero_e);

      foreach (vt[k]) begin
         @(posedge clk); #1;
         cur = vt[k].i; in_valid = 1; out_ready = 1;
         @(posedge clk); #1 in_valid = 0;
         @(negedge clk);
         chk($sformatf("vec%0d.out_valid", k), 64'(out_valid), 1);
         chk_out($sformatf("vec%0d", k), vt[k].e);
      end
      @(posedge clk); #1;

      sa = mk(0, 34, 32'hA, 1, 0);
      sb = mk(12, 0, 32'hB, 2, 16'h00F0);
      out_ready = 0; cur = sa; in_valid = 1;
      @(posedge clk); #1 cur = sb;
      @(posedge clk); #1 cur = mk(13, 0, 32'hC, 3, 16'h0C0C);
      @(negedge clk);
      chk("two.in_ready", 64'(in_ready), 0);
      chk_out("two.hold0", model(sa));
      @(posedge clk); #1 in_valid = 0;
      @(negedge clk);
      chk("two.in_ready_hold", 64'(in_ready), 0);
      chk_out("two.hold1", model(sa));
      out_ready = 1;
      @(posedge clk); @(negedge clk);
      chk("two.second_valid", 64'(out_valid), 1);
      chk("two.second_ready", 64'(in_ready), 1);
      chk_out("two.second", model(sb));
      @(posedge clk); @(negedge clk);
      chk("two.drained", 64'(out_valid), 0);

      #1 out_ready = 0; cur = sa; in_valid = 1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1;
      @(posedge clk); @(negedge clk);
      chk("mrst.out_valid", 64'(out_valid), 0);
      chk("mrst.in_ready", 64'(in_ready), 1);
      chk_out("mrst", zero_e);
      #1 reset = 0; in_valid = 0;

      q.delete();
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         begin
            int sel;
            sel = $urandom_range(0, 9);
            cur = '0;
            case (sel)
               0: cur.op = 8;  1: cur.op = 10;
               2: cur.op = 12; 3: cur.op = 13;
               4: cur.op = 6'($urandom);
               5: cur.fn = 6'($urandom);
               default: cur.fn = (sel == 6) ? 6'd32 : (sel == 7) ? 6'd34
                                 : (sel == 8) ? 6'd42 : 6'd37;
            endcase
            cur.rs = 5'($urandom_range(0, 7));
            cur.rt = 5'($urandom_range(0, 7));
            cur.rd = 5'($urandom);
            cur.rsd = $urandom; cur.rtd = $urandom;
            cur.imm = 16'($urandom);
            cur.fv = 1'($urandom); cur.fd = 5'($urandom_range(0, 7));
            cur.fdata = $urandom;
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
         end
         @(negedge clk);
         chk("rnd.in_ready", 64'(in_ready), 64'(q.size() < 2));
         chk("rnd.out_valid", 64'(out_valid), 64'(q.size() > 0));
         if (q.size() > 0) begin
            e0 = q[0];
            chk_out($sformatf("rnd%0d", n), e0);
         end
         acc = in_valid && (q.size() < 2);
         pp  = out_ready && (q.size() > 0);
         if (pp) void'(q.pop_front());
         if (acc) q.push_back(model(cur));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
